// File: rtl/dmem_lane.sv
// dmem_lane: single-port byte-lane data memory for the load/store unit.
// valid/ready request in, valid/ready response out, sign/zero-extended loads,
// per-byte store lanes, fault reporting for misaligned/illegal/out-of-range.
// Params: ADDR_W (word-address bits), INIT_FILE (image name; not loaded here).
// Ports : clk, rst (sync, active-high), req_* (request), resp_* (response).
// Build : define DMEM_OUT_REG_EN for a second output register stage.
module dmem_lane #(
    parameter int ADDR_W    = 18,
    parameter     INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       r_mem [DEPTH];
    logic [31:0]       r_rword;

    logic              r_s1_valid;
    logic [1:0]        r_s1_lane;
    logic [1:0]        r_s1_size;
    logic              r_s1_uns;
    logic              r_s1_fault;
    logic              r_s1_we;

    logic              w_adv;
    logic              w_acc;
    logic              w_fault;
    logic [ADDR_W-1:0] w_idx;
    logic [3:0]        w_be;
    logic [31:0]       w_wdat;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_ext;
    logic [31:0]       w_s1_data;

    // Pipeline moves only when the output slot is free or being drained.
    assign w_adv     = !rst && (!resp_valid || resp_ready);
    assign req_ready = w_adv;
    assign w_acc     = w_adv && req_valid;
    assign w_idx     = req_addr[ADDR_W+1:2];

    assign w_fault = (req_size == 2'd3)
                   || (req_size == 2'd1 && req_addr[0])
                   || (req_size == 2'd2 && req_addr[1:0] != 2'd0)
                   || (|req_addr[31:ADDR_W+2]);

    // Store data is replicated so each enabled lane sees its own byte.
    always_comb begin
        w_be   = 4'b0000;
        w_wdat = req_wdata;
        case (req_size)
            2'd0: begin
                w_be   = 4'b0001 << req_addr[1:0];
                w_wdat = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                w_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdat = {2{req_wdata[15:0]}};
            end
            2'd2: begin
                w_be   = 4'b1111;
                w_wdat = req_wdata;
            end
            default: begin
                w_be   = 4'b0000;
                w_wdat = req_wdata;
            end
        endcase
    end

    // RAM port: no reset, accessed only when the pipeline advances.
    always_ff @(posedge clk) begin
        if (w_acc && !w_fault) begin
            if (req_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_be[i]) begin
                        r_mem[w_idx][i*8 +: 8] <= w_wdat[i*8 +: 8];
                    end
                end
            end else begin
                r_rword <= r_mem[w_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_fault <= 1'b0;
            r_s1_we    <= 1'b0;
            r_s1_lane  <= 2'd0;
            r_s1_size  <= 2'd0;
            r_s1_uns   <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= req_valid;
            r_s1_fault <= w_fault;
            r_s1_we    <= req_we;
            r_s1_lane  <= req_addr[1:0];
            r_s1_size  <= req_size;
            r_s1_uns   <= req_unsigned;
        end
    end

    always_comb begin
        w_byte = r_rword[7:0];
        case (r_s1_lane)
            2'd0:    w_byte = r_rword[7:0];
            2'd1:    w_byte = r_rword[15:8];
            2'd2:    w_byte = r_rword[23:16];
            default: w_byte = r_rword[31:24];
        endcase
        w_half = r_s1_lane[1] ? r_rword[31:16] : r_rword[15:0];
        w_ext  = r_rword;
        case (r_s1_size)
            2'd0:    w_ext = {{24{!r_s1_uns && w_byte[7]}}, w_byte};
            2'd1:    w_ext = {{16{!r_s1_uns && w_half[15]}}, w_half};
            default: w_ext = r_rword;
        endcase
    end

    // Stores, faults and empty slots all present zero data.
    assign w_s1_data = (r_s1_valid && !r_s1_we && !r_s1_fault) ? w_ext : 32'd0;

`ifdef DMEM_OUT_REG_EN
    logic        r_s2_valid;
    logic [31:0] r_s2_rdata;
    logic        r_s2_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_rdata <= 32'd0;
            r_s2_fault <= 1'b0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_rdata <= w_s1_data;
            r_s2_fault <= r_s1_valid && r_s1_fault;
        end
    end

    assign resp_valid = r_s2_valid;
    assign resp_rdata = r_s2_rdata;
    assign resp_fault = r_s2_fault;
`else
    assign resp_valid = r_s1_valid;
    assign resp_rdata = w_s1_data;
    assign resp_fault = r_s1_valid && r_s1_fault;
`endif

endmodule

// File: tb/tb_dmem_lane.sv
// tb_dmem_lane: randomized scoreboard bench for dmem_lane.
// Byte-array reference model; monitor pops expected responses in order.
module tb_dmem_lane;

    localparam int ADDR_W = 18;
`ifdef DMEM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    bit          rand_rdy = 1'b0;
    logic        rdy_fixed = 1'b0;
    logic        rdy_rnd = 1'b1;

    assign resp_ready = rand_rdy ? rdy_rnd : rdy_fixed;

    always #5 clk = ~clk;

    always @(negedge clk) rdy_rnd = ($urandom_range(0, 3) != 0);

    dmem_lane #(.ADDR_W(ADDR_W), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        f;
    } exp_t;

    exp_t        q[$];
    bit [7:0]    mem[int unsigned];
    int          checks = 0;
    int          errors = 0;
    int          stalls = 0;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", n, a, e);
        end
    endtask

    function automatic bit model_fault(input int sz, input int unsigned a);
        if (sz == 3) return 1'b1;
        if ((a % (1 << sz)) != 0) return 1'b1;
        if (a >= (32'd4 << ADDR_W)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input int sz, input bit uns,
                                               input int unsigned a);
        int          n = 1 << sz;
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mem[a + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance
    // with the request still driven so the next call can stream.
    task automatic issue(input bit we, input int sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd);
        bit          acc = 1'b0;
        int          n = 0;
        int unsigned ua = a;
        bit          f;
        exp_t        e;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz[1:0];
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        while (!acc) begin
            #4;
            if (req_ready) begin
                acc = 1'b1;
                f   = model_fault(sz, ua);
                e.f = f;
                e.d = 32'd0;
                if (we) begin
                    if (!f)
                        for (int i = 0; i < (1 << sz); i++)
                            mem[ua + i] = wd[8*i +: 8];
                end else if (!f) begin
                    e.d = model_load(sz, uns, ua);
                end
                q.push_back(e);
            end
            @(posedge clk);
            @(negedge clk);
            if (!acc) begin
                stalls++;
                n++;
                if (n > 200) begin
                    chk("issue_timeout", 32'(n), 32'd200);
                    break;
                end
            end
        end
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    // Monitor: pops on every handshake, checks hold/ready during stalls.
    bit          prev_stall = 1'b0;
    logic [31:0] prev_d;
    logic        prev_f;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            chk("req_ready", {31'd0, req_ready},
                {31'd0, (!resp_valid || resp_ready)});
            if (prev_stall) begin
                chk("hold_valid", {31'd0, resp_valid}, 32'd1);
                chk("hold_rdata", resp_rdata, prev_d);
                chk("hold_fault", {31'd0, resp_fault}, {31'd0, prev_f});
            end
            if (resp_valid && resp_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("rdata", resp_rdata, e.d);
                    chk("fault", {31'd0, resp_fault}, {31'd0, e.f});
                end
            end
            prev_stall = resp_valid && !resp_ready;
            prev_d     = resp_rdata;
            prev_f     = resp_fault;
        end
    end

    initial begin
        int          cnt;
        int          sz;
        logic [31:0] a;
        int          pick;

        repeat (3) @(negedge clk);
        #4;
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_fault", {31'd0, resp_fault}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        rdy_fixed = 1'b1;

        for (int w = 0; w < 128; w++) issue(1'b1, 2, 1'b0, 32'(w * 4), $urandom);
        idle();
        drain();

        issue(1'b0, 2, 1'b0, 32'h40, 32'd0);
        idle();
        cnt = 1;
        while (!resp_valid && cnt < 6) begin
            @(negedge clk);
            cnt++;
        end
        chk("latency", 32'(cnt), 32'(LAT));
        drain();

        issue(1'b1, 2, 1'b0, 32'h100, 32'h8081_7F01);
        issue(1'b0, 0, 1'b0, 32'h100, 32'd0);
        issue(1'b0, 0, 1'b0, 32'h101, 32'd0);
        issue(1'b0, 0, 1'b0, 32'h103, 32'd0);
        issue(1'b0, 0, 1'b1, 32'h103, 32'd0);
        issue(1'b1, 2, 1'b0, 32'h100, 32'hAAAA_AAAA);
        issue(1'b1, 1, 1'b0, 32'h102, 32'h0000_1234);
        issue(1'b0, 2, 1'b0, 32'h100, 32'd0);
        issue(1'b1, 1, 1'b0, 32'h102, 32'h0000_8000);
        issue(1'b0, 1, 1'b0, 32'h102, 32'd0);
        issue(1'b0, 2, 1'b0, 32'h102, 32'd0);
        issue(1'b1, 1, 1'b0, 32'h101, 32'h0000_5555);
        issue(1'b0, 2, 1'b0, 32'h100, 32'd0);
        issue(1'b0, 2, 1'b0, 32'h0010_0000, 32'd0);
        issue(1'b1, 3, 1'b0, 32'h104, 32'hFFFF_FFFF);
        issue(1'b0, 2, 1'b0, 32'h104, 32'd0);
        idle();
        drain();

        rdy_fixed = 1'b0;
        fork
            begin
                issue(1'b0, 2, 1'b0, 32'h000, 32'd0);
                issue(1'b0, 0, 1'b0, 32'h007, 32'd0);
                issue(1'b0, 1, 1'b1, 32'h00A, 32'd0);
                issue(1'b0, 2, 1'b0, 32'h00C, 32'd0);
                idle();
            end
            begin
                cnt = 0;
                while (!resp_valid && cnt < 20) begin
                    @(negedge clk);
                    cnt++;
                end
                repeat (3) @(negedge clk);
                rdy_fixed = 1'b1;
            end
        join
        drain();

        rdy_fixed = 1'b0;
        issue(1'b0, 2, 1'b0, 32'h180, 32'd0);
        idle();
        repeat (LAT - 1) @(negedge clk);
        chk("pending", {31'd0, resp_valid}, 32'd1);
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h180;
        req_wdata = 32'hDEAD_BEEF;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        idle();
        #4;
        chk("rst_drop", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        rdy_fixed = 1'b1;
        repeat (3) @(negedge clk);
        issue(1'b0, 2, 1'b0, 32'h180, 32'd0);
        idle();
        drain();

        stalls = 0;
        for (int i = 0; i < 256; i++) begin
            sz = $urandom_range(0, 2);
            a  = 32'($urandom_range(0, 32'h1FF)) & ~32'((1 << sz) - 1);
            issue(1'b1, sz, 1'b0, a, $urandom);
            issue(1'b0, sz, 1'($urandom_range(0, 1)), a, 32'd0);
        end
        idle();
        chk("stream_stalls", 32'(stalls), 32'd0);
        drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            sz   = $urandom_range(0, 3);
            pick = $urandom_range(0, 9);
            if (pick == 0)
                a = 32'h0010_0000 + 32'($urandom_range(0, 32'hFFFF));
            else if (pick < 3)
                a = 32'($urandom_range(0, 32'h1FF));
            else
                a = 32'($urandom_range(0, 32'h1FF)) & ~32'((1 << (sz % 3)) - 1);
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                  a, $urandom);
        end
        idle();
        @(negedge clk);
        rand_rdy = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
